// File: rtl/peak_period_meter.sv
// peak_period_meter: measures peak-to-peak sample distance with a running average, amplitude, count, gap timeout and stream-stop freeze
//   clk, rst (async, active-high)
//   sample_en  : one upstream sample consumed this cycle
//   peak_valid : peak strobe, peak_data : signed peak value
//   src_stop   : end of stream, freezes all outputs
//   period/period_avg/avg_valid : last distance, windowed mean, window-full flag
//   peak_amp/peak_cnt           : latest peak value, saturating peak count
//   meas_valid : 1-cycle pulse on period update, timeout : sticky gap timeout, done : stream ended
module peak_period_meter #(
  parameter int N = 16,
  parameter int CW = 16,
  parameter int AVG_LOG2 = 2,
  parameter int MAX_GAP = 1000
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic          peak_valid,
  input  logic [N-1:0]  peak_data,
  input  logic          src_stop,
  output logic [CW-1:0] period,
  output logic [CW-1:0] period_avg,
  output logic          avg_valid,
  output logic [N-1:0]  peak_amp,
  output logic [7:0]    peak_cnt,
  output logic          meas_valid,
  output logic          timeout,
  output logic          done
);
  localparam int W = 1 << AVG_LOG2;
  localparam int SW = CW + AVG_LOG2;
  localparam int FW = AVG_LOG2 + 1;
  typedef enum logic [1:0] {IDLE, ARMED, MEAS, DONE} state_t;
  state_t st, nxt;
  logic [CW-1:0] gap, gap_inc;
  logic [CW-1:0] win [W];
  logic [AVG_LOG2-1:0] ptr;
  logic [SW-1:0] sum;
  logic [FW-1:0] fill;
  logic active, first, meas, tmo;
  assign period_avg = sum[SW-1:AVG_LOG2];
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  always_comb begin
    active = st == ARMED || st == MEAS;
    gap_inc = &gap ? gap : gap + CW'(sample_en);
    first = st == ARMED && peak_valid;
    meas = st == MEAS && peak_valid;
    // a peak in the same cycle as the gap limit wins over the timeout
    tmo = active && !peak_valid && gap_inc >= CW'(MAX_GAP);
    nxt = src_stop ? DONE :
          st == IDLE && sample_en ? ARMED :
          first || meas ? MEAS :
          tmo ? ARMED : st;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gap <= '0;
      ptr <= '0;
      sum <= '0;
      fill <= '0;
      for (int i = 0; i < W; i++) win[i] <= '0;
      period <= '0;
      avg_valid <= 1'b0;
      peak_amp <= '0;
      peak_cnt <= '0;
      meas_valid <= 1'b0;
      timeout <= 1'b0;
      done <= 1'b0;
    end else begin
      meas_valid <= meas;
      if (nxt == DONE) done <= 1'b1;
      if (active) gap <= first || meas || tmo ? '0 : gap_inc;
      if (first || meas) begin
        peak_amp <= peak_data;
        peak_cnt <= peak_cnt + 8'(peak_cnt != 8'hff);
      end
      if (meas) begin
        period <= gap_inc;
        win[ptr] <= gap_inc;
        ptr <= ptr + 1'b1;
        // slots not yet written hold 0, so the subtraction is exact while filling
        sum <= sum + SW'(gap_inc) - SW'(win[ptr]);
        if (!avg_valid) fill <= fill + 1'b1;
        avg_valid <= avg_valid | (fill == FW'(W - 1));
      end
      if (tmo) begin
        timeout <= 1'b1;
        ptr <= '0;
        sum <= '0;
        fill <= '0;
        avg_valid <= 1'b0;
        for (int i = 0; i < W; i++) win[i] <= '0;
      end
    end
endmodule

// File: tb/tb_peak_period_meter.sv
// tb_peak_period_meter: directed stimulus with a queue-based scoreboard checked on each meas_valid
module tb_peak_period_meter;
  localparam int N = 16;
  localparam int CW = 16;
  logic clk = 1'b0, rst = 1'b1, sample_en = 1'b0, peak_valid = 1'b0, src_stop = 1'b0;
  logic [N-1:0] peak_data = '0;
  logic [CW-1:0] period, period_avg;
  logic avg_valid, meas_valid, timeout, done;
  logic [N-1:0] peak_amp;
  logic [7:0] peak_cnt;
  typedef struct {
    logic [CW-1:0] per;
    logic          av;
    logic [CW-1:0] avg;
    logic [N-1:0]  amp;
    logic [7:0]    cnt;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  peak_period_meter #(.N(N), .CW(CW), .AVG_LOG2(2), .MAX_GAP(1000)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .peak_valid(peak_valid),
    .peak_data(peak_data), .src_stop(src_stop), .period(period),
    .period_avg(period_avg), .avg_valid(avg_valid), .peak_amp(peak_amp),
    .peak_cnt(peak_cnt), .meas_valid(meas_valid), .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (meas_valid) begin
      if (q.size() == 0) chk("unexpected_meas_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("period", period, e.per);
        chk("avg_valid", avg_valid, e.av);
        if (e.av) chk("period_avg", period_avg, e.avg);
        chk("peak_amp", peak_amp, e.amp);
        chk("peak_cnt", peak_cnt, e.cnt);
      end
    end
  end

  task automatic cyc(logic se, logic pv, logic [N-1:0] pd, logic ss);
    sample_en = se;
    peak_valid = pv;
    peak_data = pd;
    src_stop = ss;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    peak_valid = 1'b0;
    src_stop = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic pk(int p, logic [N-1:0] v);
    idle(p - 1);
    cyc(1'b1, 1'b1, v, 1'b0);
  endtask

  task automatic push(int per, logic av, int avg, logic [N-1:0] amp, int cnt);
    q.push_back('{CW'(per), av, CW'(avg), amp, 8'(cnt)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(string name);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_pending"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_period", period, 0);
    chk("rst_period_avg", period_avg, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_peak_amp", peak_amp, 0);
    chk("rst_peak_cnt", peak_cnt, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // peaks at samples 3, 13, 23
    idle(2);
    cyc(1'b1, 1'b1, 16'd100, 1'b0);
    push(10, 0, 0, 16'd98, 2);
    pk(10, 16'd98);
    push(10, 0, 0, 16'd101, 3);
    pk(10, 16'd101);
    chk("t2_amp", peak_amp, 101);
    chk("t2_cnt", peak_cnt, 3);
    chk("t2_avg_valid", avg_valid, 0);
    drain("t2");
    // periods 8..16, then a full-length gap timeout
    do_reset();
    idle(1);
    cyc(1'b1, 1'b1, 16'hFFFB, 1'b0);
    push(8, 0, 0, 16'd7, 2);
    pk(8, 16'd7);
    push(10, 0, 0, 16'hFED4, 3);
    pk(10, 16'hFED4);
    push(12, 0, 0, 16'd1234, 4);
    pk(12, 16'd1234);
    push(14, 1, 11, 16'hFFFF, 5);
    pk(14, 16'hFFFF);
    push(16, 1, 13, 16'd42, 6);
    pk(16, 16'd42);
    chk("t3_avg_valid", avg_valid, 1);
    chk("t3_avg", period_avg, 13);
    idle(999);
    chk("t5_no_timeout_yet", timeout, 0);
    chk("t5_avg_valid_held", avg_valid, 1);
    idle(1);
    chk("t5_timeout", timeout, 1);
    chk("t5_avg_valid_clr", avg_valid, 0);
    pk(5, 16'd77);
    chk("t5_rearm_cnt", peak_cnt, 7);
    chk("t5_rearm_amp", peak_amp, 77);
    push(6, 0, 0, 16'd88, 8);
    pk(6, 16'd88);
    chk("t5_timeout_sticky", timeout, 1);
    drain("t5");
    // sample_en every other cycle, peaks 20 cycles apart
    do_reset();
    idle(1);
    cyc(1'b1, 1'b1, 16'd500, 1'b0);
    for (int i = 1; i < 20; i++) cyc(i % 2 == 0, 1'b0, '0, 1'b0);
    push(10, 0, 0, 16'd600, 2);
    cyc(1'b1, 1'b1, 16'd600, 1'b0);
    chk("t4_period", period, 10);
    drain("t4");
    // stop coinciding with a peak
    do_reset();
    idle(1);
    cyc(1'b1, 1'b1, 16'd10, 1'b0);
    push(9, 0, 0, 16'd20, 2);
    idle(8);
    cyc(1'b1, 1'b1, 16'd20, 1'b1);
    chk("t6_done", done, 1);
    repeat (3) pk(3, 16'd30);
    chk("t6_period_frozen", period, 9);
    chk("t6_cnt_frozen", peak_cnt, 2);
    chk("t6_amp_frozen", peak_amp, 20);
    chk("t6_done_held", done, 1);
    drain("t6");
    // async reset in MEAS with gap 5
    do_reset();
    idle(1);
    cyc(1'b1, 1'b1, 16'd1, 1'b0);
    push(4, 0, 0, 16'd2, 2);
    pk(4, 16'd2);
    idle(5);
    rst = 1'b1;
    #1;
    chk("t1_period", period, 0);
    chk("t1_cnt", peak_cnt, 0);
    chk("t1_amp", peak_amp, 0);
    chk("t1_meas_valid", meas_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    cyc(1'b1, 1'b1, 16'd3, 1'b0);
    chk("t1_first_cnt", peak_cnt, 1);
    chk("t1_first_no_meas", meas_valid, 0);
    idle(2);
    drain("t1");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
